// File: rtl/conv1d_tap_sequencer_if.sv
// Handshake bundle between the tap sequencer, its sample producer and the
// conv1d MAC that consumes the serialised window.
interface conv1d_tap_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_TAPS = 5,
    parameter int TAP_W    = $clog2(NUM_TAPS)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAP_W-1:0] out_tap;
    logic             out_last;
    logic             win_full;

    // Environment side: drives samples in and accepts tap beats.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_tap, out_last, win_full
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_tap, out_last, win_full
    );
endinterface

// File: rtl/conv1d_tap_sequencer.sv
// Sliding-window tap sequencer for conv1d: keeps the last NUM_TAPS samples
// and, each time a new sample completes a full window, streams the window
// out one tap per beat, oldest first.
module conv1d_tap_sequencer #(
    parameter int WIDTH    = 8,
    parameter int NUM_TAPS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    conv1d_tap_sequencer_if.slave        bus
);
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(NUM_TAPS - 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);

    typedef enum logic {FILL, EMIT} state_t;

    state_t           state;
    logic [WIDTH-1:0] win [NUM_TAPS];
    logic [CNT_W-1:0] cnt;
    logic [TAP_W-1:0] tap;
    logic             accept;
    logic             emit_last;

    // Handshake decode; in_ready is killed by rst/clear so a sample offered
    // during a flush is dropped rather than landing in the fresh window.
    assign bus.in_ready  = (state == FILL) && !rst && !clear;
    assign accept        = bus.in_valid && bus.in_ready;
    assign emit_last     = (tap == TAP_LAST);

    // Output view is a pure function of registered state.
    assign bus.out_valid = (state == EMIT);
    assign bus.out_data  = (state == EMIT) ? win[tap] : '0;
    assign bus.out_tap   = tap;
    assign bus.out_last  = (state == EMIT) && emit_last;
    assign bus.win_full  = (cnt == CNT_FULL);

    // Window shift register, fill counter and FILL/EMIT sequencing.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= FILL;
            cnt   <= '0;
            tap   <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                win[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_TAPS - 1; i++) begin
                    win[i] <= win[i+1];
                end
                win[NUM_TAPS-1] <= bus.in_data;
                if (cnt != CNT_FULL) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            case (state)
                FILL: begin
                    // Window is complete once this accept lands; cnt stays
                    // saturated after the first fill, giving stride-1 sliding.
                    if (accept && (cnt == CNT_FULL || cnt == CNT_PRE)) begin
                        state <= EMIT;
                        tap   <= '0;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (emit_last) begin
                            state <= FILL;
                            tap   <= '0;
                        end else begin
                            tap <= tap + TAP_W'(1);
                        end
                    end
                end
                default: begin
                    state <= FILL;
                    tap   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_tap_sequencer.sv
// Directed bench for conv1d_tap_sequencer (WIDTH=8, NUM_TAPS=5): a per-cycle
// vector table plus hand-written reset and sliding-throughput sequences.
module tb_conv1d_tap_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic clear;

    conv1d_tap_sequencer_if #(.WIDTH(8), .NUM_TAPS(5)) bus ();

    conv1d_tap_sequencer #(.WIDTH(8), .NUM_TAPS(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_tap;
        logic       e_last;
        logic       e_full;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = -1;

    task automatic add(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic clr, input logic e_ir, input logic e_ov,
                       input logic [7:0] e_od, input logic [2:0] e_tap,
                       input logic e_last, input logic e_full);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.clr = clr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_tap = e_tap;
        v.e_last = e_last; v.e_full = e_full;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        int beats;
        int first;
        int span;
        bit done;

        // Table: one row per cycle; inputs for the cycle, outputs seen in it.
        //    iv  id     rdy clr  ir  ov  od     tap last full
        for (int i = 0; i < 5; i++)                       // fill 01..05
            add(1, 8'(i + 1), 1, 0, 1, 0, 8'h00, 3'd0, 0, 0);
        for (int i = 0; i < 5; i++)                       // emit, 06 blocked
            add(1, 8'h06, 1, 0, 0, 1, 8'(i + 1), 3'(i), (i == 4), 1);
        add(1, 8'h06, 1, 0, 1, 0, 8'h00, 3'd0, 0, 1);     // slide in 06
        add(0, 8'h00, 1, 0, 0, 1, 8'h02, 3'd0, 0, 1);
        add(0, 8'h00, 1, 0, 0, 1, 8'h03, 3'd1, 0, 1);
        for (int i = 0; i < 3; i++)                       // backpressure at tap 2
            add(0, 8'h00, 0, 0, 0, 1, 8'h04, 3'd2, 0, 1);
        add(0, 8'h00, 1, 0, 0, 1, 8'h04, 3'd2, 0, 1);
        add(0, 8'h00, 1, 0, 0, 1, 8'h05, 3'd3, 0, 1);
        add(0, 8'h00, 1, 0, 0, 1, 8'h06, 3'd4, 1, 1);
        add(1, 8'h07, 1, 0, 1, 0, 8'h00, 3'd0, 0, 1);     // slide in 07
        add(0, 8'h00, 1, 0, 0, 1, 8'h03, 3'd0, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1, 8'h04, 3'd1, 0, 1);     // clear mid-emit
        for (int i = 0; i < 5; i++)                       // refill 10..14
            add(1, 8'(8'h10 + i), 1, 0, 1, 0, 8'h00, 3'd0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 8'h00, 1, 0, 0, 1, 8'(8'h10 + i), 3'(i), (i == 4), 1);
        add(1, 8'h77, 1, 1, 0, 0, 8'h00, 3'd0, 0, 1);     // clear + in_valid
        add(0, 8'h00, 1, 0, 1, 0, 8'h00, 3'd0, 0, 0);
        for (int i = 0; i < 5; i++)                       // 77 must not count
            add(1, 8'(8'h21 + i), 1, 0, 1, 0, 8'h00, 3'd0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 8'h00, 1, 0, 0, 1, 8'(8'h21 + i), 3'(i), (i == 4), 1);

        // Reset held two cycles with a sample offered that must be ignored.
        rst = 1'b1; clear = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.out_ready = 1'b1;
        #2;
        chk("rst_in_ready_0", 32'(bus.in_ready), 32'd0);
        @(negedge clk); #2;
        chk("rst_in_ready_1", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_win_full", 32'(bus.win_full), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            row = i;
            rst = 1'b0;
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].id;
            bus.out_ready = vecs[i].ordy;
            clear         = vecs[i].clr;
            #2;
            chk("in_ready",  32'(bus.in_ready),  32'(vecs[i].e_ir));
            chk("out_valid", 32'(bus.out_valid), 32'(vecs[i].e_ov));
            chk("out_data",  32'(bus.out_data),  32'(vecs[i].e_od));
            chk("out_tap",   32'(bus.out_tap),   32'(vecs[i].e_tap));
            chk("out_last",  32'(bus.out_last),  32'(vecs[i].e_last));
            chk("win_full",  32'(bus.win_full),  32'(vecs[i].e_full));
        end

        // Sliding sample with consumer always ready: one accept cycle, then
        // five beats 22..26 starting the very next cycle.
        row = -2;
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h26; bus.out_ready = 1'b1;
        #2;
        chk("seq_accept", 32'(bus.in_ready), 32'd1);
        beats = 0; first = -1; span = -1; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #2;
            if (bus.out_valid) begin
                if (beats == 0) first = c;
                chk("seq_data", 32'(bus.out_data), 32'h22 + 32'(beats));
                chk("seq_tap", 32'(bus.out_tap), 32'(beats));
                beats++;
                if (bus.out_last) begin
                    done = 1'b1;
                    span = c + 1;
                end
            end
        end
        chk("seq_done", 32'(done), 32'd1);
        chk("seq_beats", 32'(beats), 32'd5);
        chk("seq_first_latency", 32'(first), 32'd0);
        chk("seq_emit_cycles", 32'(span), 32'd5);

        @(negedge clk); #2;
        chk("seq_back_to_fill", 32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
